// File: rtl/shiftadd_pkg.sv
// Shared types and defaults for the shift-add special-modulus reducers.
package shiftadd_pkg;

    localparam int MW_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        CORRECT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        MODE_MERSENNE,
        MODE_FERMAT,
        MODE_UNSUPPORTED
    } mode_t;

endpackage

// File: rtl/shiftadd_mod_classify.sv
// Combinational modulus classifier: recognises 2^k-1 and 2^(k-1)+1 and
// derives the limb width and limb mask used by the folding datapath.
module shiftadd_mod_classify
    import shiftadd_pkg::*;
#(
    parameter int MW = MW_DEFAULT,
    parameter int KW = $clog2(MW + 1)
) (
    input  logic [MW-1:0] m_i,
    input  logic [KW-1:0] k_i,
    output mode_t         mode_o,
    output logic [KW-1:0] limb_w_o,
    output logic [MW-1:0] limb_mask_o
);

    logic [MW-1:0] mers_pat;
    logic [MW-1:0] ferm_pat;
    logic [KW-1:0] lw;
    logic          k_ok_mers;
    logic          k_ok_ferm;

    // Build reference bit patterns for both families and pick the mode.
    always_comb begin
        mers_pat  = '0;
        ferm_pat  = '0;
        k_ok_mers = (int'(k_i) >= 2) && (int'(k_i) <= MW);
        k_ok_ferm = (int'(k_i) >= 3) && (int'(k_i) <= MW);
        for (int i = 0; i < MW; i++) begin
            mers_pat[i] = (i < int'(k_i));
            ferm_pat[i] = (i == 0) || (i + 1 == int'(k_i));
        end
        mode_o = MODE_UNSUPPORTED;
        lw     = k_i;
        if (k_ok_mers && (m_i == mers_pat)) begin
            mode_o = MODE_MERSENNE;
            lw     = k_i;
        end else if (k_ok_ferm && (m_i == ferm_pat)) begin
            mode_o = MODE_FERMAT;
            lw     = k_i - KW'(1);
        end
        limb_w_o = lw;
    end

    // Low-order mask of limb_w_o ones, used to extract one limb.
    always_comb begin
        limb_mask_o = '0;
        for (int i = 0; i < MW; i++) begin
            limb_mask_o[i] = (i < int'(lw));
        end
    end

endmodule

// File: rtl/shiftadd_reduce_param.sv
// Serial shift-add reducer: folds one limb of x per cycle into a signed
// accumulator, then adds/subtracts m until the residue lies in [0, m).
//
// Handshake: a request transfers on a rising edge where in_valid_i and
// in_ready_o are both high; a result transfers on a rising edge where
// out_valid_o and out_ready_i are both high. out_valid_o, result_o and
// err_o hold steady until that transfer.
module shiftadd_reduce_param
    import shiftadd_pkg::*;
#(
    parameter int MW = MW_DEFAULT,
    parameter int XW = 2 * MW,
    parameter int KW = $clog2(MW + 1),
    parameter int AW = MW + $clog2(XW) + 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [XW-1:0] x_i,
    input  logic [MW-1:0] m_i,
    input  logic [KW-1:0] m_bl_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [MW-1:0] result_o,
    output logic          err_o,
    output state_t        state_o
);

    localparam int JW = $clog2(XW + 1);

    state_t                state_q, state_d;
    mode_t                 mode_q, mode_d, cls_mode;
    logic [KW-1:0]         lw_q, lw_d, cls_lw;
    logic [MW-1:0]         mask_q, mask_d, cls_mask;
    logic [MW-1:0]         m_q, m_d;
    logic [XW-1:0]         x_q, x_d, x_rest;
    logic [JW-1:0]         j_q, j_d;
    logic signed [AW-1:0]  acc_q, acc_d, limb_ext, m_ext;

    shiftadd_mod_classify #(
        .MW (MW),
        .KW (KW)
    ) u_classify (
        .m_i         (m_i),
        .k_i         (m_bl_i),
        .mode_o      (cls_mode),
        .limb_w_o    (cls_lw),
        .limb_mask_o (cls_mask)
    );

    // x_q holds the not-yet-folded part of x, so the current limb is always
    // its low bits and the exit test is simply "nothing left above it".
    assign x_rest   = x_q >> lw_q;
    assign limb_ext = $signed({{(AW - MW){1'b0}}, x_q[MW-1:0] & mask_q});
    assign m_ext    = $signed({{(AW - MW){1'b0}}, m_q});

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= MODE_MERSENNE;
            lw_q    <= '0;
            mask_q  <= '0;
            m_q     <= '0;
            x_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lw_q    <= lw_d;
            mask_q  <= mask_d;
            m_q     <= m_d;
            x_q     <= x_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        lw_d    = lw_q;
        mask_d  = mask_q;
        m_d     = m_q;
        x_d     = x_q;
        j_d     = j_q;
        acc_d   = acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    x_d     = x_i;
                    m_d     = m_i;
                    lw_d    = cls_lw;
                    mask_d  = cls_mask;
                    mode_d  = cls_mode;
                    acc_d   = '0;
                    j_d     = '0;
                    state_d = (cls_mode == MODE_UNSUPPORTED) ? DONE : FOLD;
                end
            end
            FOLD: begin
                // Fermat limbs alternate sign since 2^L == -1 mod m.
                if ((mode_q == MODE_FERMAT) && j_q[0]) begin
                    acc_d = acc_q - limb_ext;
                end else begin
                    acc_d = acc_q + limb_ext;
                end
                x_d = x_rest;
                j_d = j_q + JW'(1);
                if (x_rest == '0) begin
                    state_d = CORRECT;
                end
            end
            CORRECT: begin
                if (acc_q[AW-1]) begin
                    acc_d = acc_q + m_ext;
                end else if (acc_q >= m_ext) begin
                    acc_d = acc_q - m_ext;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        err_o       = 1'b0;
        result_o    = '0;
        state_o     = state_q;
        if (state_q == IDLE) begin
            in_ready_o = 1'b1;
        end
        if (state_q == DONE) begin
            out_valid_o = 1'b1;
            if (mode_q == MODE_UNSUPPORTED) begin
                err_o = 1'b1;
            end else begin
                result_o = acc_q[MW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_shiftadd_reduce_param.sv
// Directed bench for shiftadd_reduce_param with hand-computed residues.
module tb_shiftadd_reduce_param;
    import shiftadd_pkg::*;

    localparam int MW = 64;
    localparam int XW = 128;
    localparam int KW = 7;

    logic          clk_i;
    logic          rst_ni;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [XW-1:0] x_i;
    logic [MW-1:0] m_i;
    logic [KW-1:0] m_bl_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [MW-1:0] result_o;
    logic          err_o;
    state_t        state_o;

    int total;
    int bad;

    shiftadd_reduce_param dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_i         (x_i),
        .m_i         (m_i),
        .m_bl_i      (m_bl_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .err_o       (err_o),
        .state_o     (state_o)
    );

    // Clock.
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Present one request, wait (bounded) for the result, check it, then
    // optionally consume it.
    task automatic start_req(input logic [XW-1:0] x, input logic [MW-1:0] m, input logic [KW-1:0] k,
                             input string tag);
        @(negedge clk_i);
        check({tag, ".in_ready"}, XW'(in_ready_o), XW'(1));
        in_valid_i = 1'b1;
        x_i        = x;
        m_i        = m;
        m_bl_i     = k;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        x_i        = '0;
    endtask

    task automatic wait_result(input logic [MW-1:0] er, input logic ee, input int lat, input string tag);
        int cnt;
        cnt = 0;
        while (!out_valid_o && cnt < 300) begin
            @(posedge clk_i);
            #1;
            cnt++;
        end
        check({tag, ".latency"}, XW'(cnt), XW'(lat));
        check({tag, ".result"}, XW'(result_o), XW'(er));
        check({tag, ".err"}, XW'(err_o), XW'(ee));
    endtask

    task automatic consume(input string tag);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check({tag, ".valid_dropped"}, XW'(out_valid_o), XW'(0));
    endtask

    task automatic do_req(input logic [XW-1:0] x, input logic [MW-1:0] m, input logic [KW-1:0] k,
                          input logic [MW-1:0] er, input logic ee, input int lat, input string tag);
        start_req(x, m, k, tag);
        wait_result(er, ee, lat, tag);
        consume(tag);
    endtask

    logic [MW-1:0] m61;
    logic [MW-1:0] held_res;

    initial begin
        total       = 0;
        bad         = 0;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        x_i         = '0;
        m_i         = '0;
        m_bl_i      = '0;
        m61         = (64'd1 << 61) - 64'd1;

        // Reset values.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst.out_valid", XW'(out_valid_o), XW'(0));
        check("rst.result", XW'(result_o), XW'(0));
        check("rst.err", XW'(err_o), XW'(0));
        check("rst.state", XW'(state_o), XW'(IDLE));
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("rst.in_ready", XW'(in_ready_o), XW'(1));

        // Mersenne 2^61-1.
        do_req(128'd1 << 64, m61, 7'd61, 64'd8, 1'b0, 3, "m61_2p64");
        do_req({128{1'b1}}, m61, 7'd61, 64'd63, 1'b0, 6, "m61_full");

        // Fermat 65537.
        do_req(128'd1 << 32, 64'd65537, 7'd17, 64'd1, 1'b0, 4, "f17_2p32");
        do_req(128'd1 << 16, 64'd65537, 7'd17, 64'd65536, 1'b0, 4, "f17_2p16");
        do_req(128'd0, 64'd65537, 7'd17, 64'd0, 1'b0, 2, "f17_zero");

        // Mersenne 7.
        do_req(128'd5, 64'd7, 7'd3, 64'd5, 1'b0, 2, "m7_x5");
        do_req(128'd7, 64'd7, 7'd3, 64'd0, 1'b0, 3, "m7_x7");
        do_req(128'd14, 64'd7, 7'd3, 64'd0, 1'b0, 4, "m7_x14");

        // Unsupported moduli.
        do_req(128'd99, 64'd10, 7'd4, 64'd0, 1'b1, 0, "unsup_m10");
        do_req(128'd99, 64'd1, 7'd1, 64'd0, 1'b1, 0, "unsup_k1");

        // Back-pressure: result held, new requests ignored.
        start_req(128'd1 << 64, m61, 7'd61, "hold");
        wait_result(64'd8, 1'b0, 3, "hold");
        held_res = result_o;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            x_i        = 128'd12345;
            m_i        = 64'd7;
            m_bl_i     = 7'd3;
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
            check("hold.valid", XW'(out_valid_o), XW'(1));
            check("hold.result", XW'(result_o), XW'(held_res));
            check("hold.err", XW'(err_o), XW'(0));
            check("hold.in_ready", XW'(in_ready_o), XW'(0));
        end
        consume("hold");
        check("hold.in_ready_after", XW'(in_ready_o), XW'(1));

        // Reset in the middle of a multi-cycle fold.
        start_req({128{1'b1}}, m61, 7'd61, "midrst");
        @(posedge clk_i);
        #1;
        check("midrst.in_fold", XW'(state_o), XW'(FOLD));
        rst_ni = 1'b0;
        #1;
        check("midrst.out_valid", XW'(out_valid_o), XW'(0));
        check("midrst.result", XW'(result_o), XW'(0));
        check("midrst.err", XW'(err_o), XW'(0));
        check("midrst.state", XW'(state_o), XW'(IDLE));
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("midrst.in_ready", XW'(in_ready_o), XW'(1));
        do_req(128'd1 << 64, m61, 7'd61, 64'd8, 1'b0, 3, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
